// File: rtl/test_result_monitor.sv
// rtl/test_result_monitor.sv - snoops CPU writes to a result byte and latches a PASS/FAIL/TIMEOUT verdict.
module test_result_monitor #(
  parameter logic [15:0] RESULT_ADDR = 16'h0040,
  parameter logic [7:0]  EXPECTED    = 8'h33,
  parameter logic [15:0] TIMEOUT     = 16'd70
) (
  input  logic        ph1,
  input  logic        resetb,
  input  logic [15:0] address,
  input  logic [7:0]  data_out,
  input  logic        memwrite,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [7:0]  captured,
  output logic [7:0]  hit_count,
  output logic [15:0] cycles
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  captured_q, captured_d;
  logic [7:0]  hit_count_q, hit_count_d;
  logic [15:0] cycles_q, cycles_d;
  logic        hit;
  logic        pass_hit;

  always_comb begin
    state_d     = state_q;
    captured_d  = captured_q;
    hit_count_d = hit_count_q;
    cycles_d    = cycles_q;
    hit         = 1'b0;
    pass_hit    = 1'b0;
    if (state_q == ST_RUN) begin
      hit      = memwrite && (address == RESULT_ADDR);
      pass_hit = hit && (data_out == EXPECTED);
      cycles_d = (cycles_q != 16'hFFFF) ? cycles_q + 16'd1 : cycles_q;
      if (hit) begin
        captured_d  = data_out;
        hit_count_d = (hit_count_q != 8'hFF) ? hit_count_q + 8'd1 : hit_count_q;
      end
      // A passing hit on the expiry edge beats the timeout decision.
      if (pass_hit) begin
        state_d = ST_PASS;
      end else if (cycles_d == TIMEOUT) begin
        state_d = (hit_count_d != 8'd0) ? ST_FAIL : ST_TIMEOUT;
      end
    end
  end

  always_ff @(posedge ph1 or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ST_RUN;
      captured_q  <= 8'h00;
      hit_count_q <= 8'd0;
      cycles_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      captured_q  <= captured_d;
      hit_count_q <= hit_count_d;
      cycles_q    <= cycles_d;
    end
  end

  assign pass      = (state_q == ST_PASS);
  assign fail      = (state_q == ST_FAIL);
  assign timeout   = (state_q == ST_TIMEOUT);
  assign done      = pass | fail | timeout;
  assign captured  = captured_q;
  assign hit_count = hit_count_q;
  assign cycles    = cycles_q;

endmodule
